// File: rtl/axi_adc_jesd204_pkg.sv
// PN select codes and PRBS orders shared by the JESD204 ADC/DAC channels.
package axi_adc_jesd204_pkg;

  localparam logic [3:0] PN_SEL_NPN7  = 4'h4;
  localparam logic [3:0] PN_SEL_NPN15 = 4'h5;
  localparam logic [3:0] PN_SEL_PN7   = 4'h6;
  localparam logic [3:0] PN_SEL_PN15  = 4'h7;
  localparam logic [3:0] PN_SEL_IDLE  = 4'h0;

  // x^K + x^(K-1) + 1; the second tap is always ORDER-1.
  localparam int unsigned PN7_ORDER    = 7;
  localparam int unsigned PN15_ORDER   = 15;
  localparam int unsigned SAMPLE_WIDTH = 16;

  typedef enum logic {
    PNMON_OOS  = 1'b0,
    PNMON_SYNC = 1'b1
  } pnmon_state_e;

  // Inverted-pattern selects.
  function automatic logic pn_sel_is_inv(input logic [3:0] sel);
    return (sel == PN_SEL_NPN7) || (sel == PN_SEL_NPN15);
  endfunction

  // PN7-based selects (plain or inverted).
  function automatic logic pn_sel_is_pn7(input logic [3:0] sel);
    return (sel == PN_SEL_PN7) || (sel == PN_SEL_NPN7);
  endfunction

  // Any code outside 4'h4..4'h7 parks the monitor.
  function automatic logic pn_sel_is_idle(input logic [3:0] sel);
    return (sel != PN_SEL_NPN7) && (sel != PN_SEL_NPN15) &&
           (sel != PN_SEL_PN7)  && (sel != PN_SEL_PN15);
  endfunction

endpackage

// File: rtl/ad_pn_next.sv
// Next WIDTH-bit PN word from the low ORDER bits of the previous word.
module ad_pn_next #(
  parameter int unsigned ORDER = 15,
  parameter int unsigned WIDTH = 64
) (
  input  logic [ORDER-1:0] seed,
  output logic [WIDTH-1:0] word_c
);

  // Bits resolve MSB first: each depends only on older (higher) positions.
  function automatic logic [WIDTH-1:0] pn_next(input logic [ORDER-1:0] s);
    logic [ORDER+WIDTH-1:0] st;
    st = {s, {WIDTH{1'b0}}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      st[i] = st[i+ORDER] ^ st[i+ORDER-1];
    end
    return st[WIDTH-1:0];
  endfunction

  assign word_c = pn_next(seed);

endmodule

// File: rtl/axi_adc_jesd204_pnmon.sv
// PN7/PN15 receive monitor: lock FSM, per-beat error pulse, saturating count.
module axi_adc_jesd204_pnmon
  import axi_adc_jesd204_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH = 4,
  parameter int unsigned OOS_THRESHOLD   = 16,
  parameter int unsigned ERRCNT_WIDTH    = 16
) (
  input  logic                                  adc_clk,
  input  logic                                  adc_rstn,
  input  logic                                  adc_valid,
  input  logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] adc_data,
  input  logic [3:0]                            adc_pn_sel,
  input  logic                                  adc_pn_err_clr,
  output logic                                  adc_pn_oos,
  output logic                                  adc_pn_err,
  output logic [ERRCNT_WIDTH-1:0]               adc_pn_err_count
);

  localparam int unsigned DW        = DATA_PATH_WIDTH * SAMPLE_WIDTH;
  localparam int unsigned RUN_WIDTH = 8;
  localparam logic [RUN_WIDTH-1:0] RUN_LAST = RUN_WIDTH'(OOS_THRESHOLD - 1);

  logic [DW-1:0]         word_in;
  logic [DW-1:0]         w_q;
  logic [PN15_ORDER-1:0] p_q;
  logic                  w_vld_q, p_vld_q, upd_q;
  logic [3:0]            sel_q;
  logic [DW-1:0]         e7_word, e15_word, exp_word;
  logic                  sel_chg, cmp_en, match;

  pnmon_state_e          state_q, state_d;
  logic [RUN_WIDTH-1:0]  run_q, run_d;
  logic                  err_d, oos_q, err_q;
  logic [ERRCNT_WIDTH-1:0] cnt_q;

  assign sel_chg = (adc_pn_sel != sel_q) || pn_sel_is_idle(adc_pn_sel);

  // Undo the sample swizzle and strip the optional inversion.
  always_comb begin
    word_in = '0;
    for (int i = 0; i < int'(DATA_PATH_WIDTH); i++) begin
      word_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
        adc_data[(int'(DATA_PATH_WIDTH) - 1 - i)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    if (pn_sel_is_inv(adc_pn_sel)) word_in = ~word_in;
  end

  // Stage 1: current/previous word and their valid flags.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      w_q     <= '0;
      p_q     <= '0;
      w_vld_q <= 1'b0;
      p_vld_q <= 1'b0;
      upd_q   <= 1'b0;
      sel_q   <= PN_SEL_IDLE;
    end else begin
      sel_q <= adc_pn_sel;
      upd_q <= adc_valid;
      if (adc_valid) begin
        w_q <= word_in;
        p_q <= w_q[PN15_ORDER-1:0];
      end
      if (sel_chg) begin
        w_vld_q <= adc_valid;
        p_vld_q <= 1'b0;
      end else if (adc_valid) begin
        w_vld_q <= 1'b1;
        p_vld_q <= w_vld_q;
      end
    end
  end

  ad_pn_next #(.ORDER(PN7_ORDER), .WIDTH(DW)) i_pn7 (
    .seed   (p_q[PN7_ORDER-1:0]),
    .word_c (e7_word)
  );

  ad_pn_next #(.ORDER(PN15_ORDER), .WIDTH(DW)) i_pn15 (
    .seed   (p_q),
    .word_c (e15_word)
  );

  assign exp_word = pn_sel_is_pn7(sel_q) ? e7_word : e15_word;
  assign cmp_en   = upd_q && p_vld_q;
  // All-zero words are an LFSR lockup and never count as a match.
  assign match    = (w_q == exp_word) && (w_q != '0);

  // Lock FSM next state, run counter and error strobe.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = 1'b0;
    if (sel_chg) begin
      state_d = PNMON_OOS;
      run_d   = '0;
    end else if (cmp_en) begin
      case (state_q)
        PNMON_OOS: begin
          if (!match) begin
            run_d = '0;
          end else if (run_q == RUN_LAST) begin
            state_d = PNMON_SYNC;
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_WIDTH'(1);
          end
        end
        PNMON_SYNC: begin
          if (match) begin
            run_d = '0;
          end else begin
            err_d = 1'b1;
            if (run_q == RUN_LAST) begin
              state_d = PNMON_OOS;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = PNMON_OOS;
          run_d   = '0;
        end
      endcase
    end
  end

  // Stage 2: FSM state and registered status outputs.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q <= PNMON_OOS;
      run_q   <= '0;
      oos_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      oos_q   <= (state_d == PNMON_OOS);
      err_q   <= err_d;
    end
  end

  // Saturating error counter; clear has priority over an increment.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      cnt_q <= '0;
    end else if (adc_pn_err_clr) begin
      cnt_q <= '0;
    end else if (err_d && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ERRCNT_WIDTH'(1);
    end
  end

  assign adc_pn_oos       = oos_q;
  assign adc_pn_err       = err_q;
  assign adc_pn_err_count = cnt_q;

endmodule
